// File: rtl/sample_iterator.sv
// Sample iterator: walks a grid-snapped bounding box in raster order, one sample per cycle.
// Optional performance counter output sampleCount_U is compiled in with SAMPLE_ITER_PERF_EN.
module sample_iterator #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed   [SIGFIG-1:0] tri_R13S   [VERTS][AXIS],
    input  logic unsigned [SIGFIG-1:0] color_R13U [COLORS],
    input  logic signed   [SIGFIG-1:0] box_R13S   [2][2],
    input  logic                       validTri_R13H,
    input  logic          [3:0]        subSample_RnnnnU,
    output logic                       halt_RnnnnL,
    output logic signed   [SIGFIG-1:0] tri_R14S   [VERTS][AXIS],
    output logic unsigned [SIGFIG-1:0] color_R14U [COLORS],
    output logic signed   [SIGFIG-1:0] sample_R14S [2],
    output logic                       validSamp_R14H
`ifdef SAMPLE_ITER_PERF_EN
    ,
    output logic          [31:0]       sampleCount_U
`endif
);

    typedef enum logic {
        WAIT_STATE = 1'b0,
        TEST_STATE = 1'b1
    } state_t;

    function automatic logic [SIGFIG-1:0] decode_step(input logic [3:0] code);
        logic [SIGFIG-1:0] one;
        one = {{(SIGFIG-1){1'b0}}, 1'b1};
        case (code)
            4'b0100: decode_step = one << (RADIX - 1);
            4'b0010: decode_step = one << (RADIX - 2);
            4'b0001: decode_step = one << (RADIX - 3);
            default: decode_step = one << RADIX;
        endcase
    endfunction

    state_t                      state_q, state_d;
    logic signed   [SIGFIG-1:0]  sample_q [2];
    logic signed   [SIGFIG-1:0]  sample_d [2];
    logic signed   [SIGFIG-1:0]  tri_q    [VERTS][AXIS];
    logic signed   [SIGFIG-1:0]  tri_d    [VERTS][AXIS];
    logic unsigned [SIGFIG-1:0]  color_q  [COLORS];
    logic unsigned [SIGFIG-1:0]  color_d  [COLORS];
    logic signed   [SIGFIG-1:0]  ll_x_q, ll_x_d;
    logic signed   [SIGFIG-1:0]  ur_x_q, ur_x_d;
    logic signed   [SIGFIG-1:0]  ur_y_q, ur_y_d;
    logic          [SIGFIG-1:0]  step_q, step_d;

    // One extra bit keeps x+step from wrapping past the most positive coordinate.
    logic signed   [SIGFIG:0]    x_nxt, y_nxt, ur_x_ext, ur_y_ext;
    logic                        x_fits, y_fits, box_ok;

    always_comb begin
        x_nxt    = {sample_q[0][SIGFIG-1], sample_q[0]} + {1'b0, step_q};
        y_nxt    = {sample_q[1][SIGFIG-1], sample_q[1]} + {1'b0, step_q};
        ur_x_ext = {ur_x_q[SIGFIG-1], ur_x_q};
        ur_y_ext = {ur_y_q[SIGFIG-1], ur_y_q};
        x_fits   = (x_nxt <= ur_x_ext);
        y_fits   = (y_nxt <= ur_y_ext);
        box_ok   = !(box_R13S[0][0] > box_R13S[1][0]) && !(box_R13S[0][1] > box_R13S[1][1]);
    end

    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        tri_d    = tri_q;
        color_d  = color_q;
        ll_x_d   = ll_x_q;
        ur_x_d   = ur_x_q;
        ur_y_d   = ur_y_q;
        step_d   = step_q;
        case (state_q)
            WAIT_STATE: begin
                if (validTri_R13H && box_ok) begin
                    tri_d       = tri_R13S;
                    color_d     = color_R13U;
                    ll_x_d      = box_R13S[0][0];
                    ur_x_d      = box_R13S[1][0];
                    ur_y_d      = box_R13S[1][1];
                    step_d      = decode_step(subSample_RnnnnU);
                    sample_d[0] = box_R13S[0][0];
                    sample_d[1] = box_R13S[0][1];
                    state_d     = TEST_STATE;
                end
            end
            TEST_STATE: begin
                if (x_fits) begin
                    sample_d[0] = x_nxt[SIGFIG-1:0];
                end else if (y_fits) begin
                    sample_d[0] = ll_x_q;
                    sample_d[1] = y_nxt[SIGFIG-1:0];
                end else begin
                    state_d = WAIT_STATE;
                end
            end
            default: state_d = WAIT_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= WAIT_STATE;
            sample_q <= '{default: '0};
            tri_q    <= '{default: '0};
            color_q  <= '{default: '0};
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            tri_q    <= tri_d;
            color_q  <= color_d;
        end
    end

    // Box extents and step are only consulted while iterating, so they need no reset.
    always_ff @(posedge clk) begin
        ll_x_q <= ll_x_d;
        ur_x_q <= ur_x_d;
        ur_y_q <= ur_y_d;
        step_q <= step_d;
    end

    assign halt_RnnnnL    = (state_q == WAIT_STATE);
    assign validSamp_R14H = (state_q == TEST_STATE);
    assign sample_R14S    = sample_q;
    assign tri_R14S       = tri_q;
    assign color_R14U     = color_q;

`ifdef SAMPLE_ITER_PERF_EN
    logic [31:0] count_q, count_d;

    always_comb begin
        count_d = count_q + {31'd0, validSamp_R14H};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign sampleCount_U = count_q;
`endif

endmodule

// File: tb/tb_sample_iterator.sv
// Self-checking bench for sample_iterator: table of box cases, reset abort, and random boxes
// checked against a nested-loop raster model.
module tb_sample_iterator;

    localparam int SIGFIG = 24;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;
    localparam int BOUND  = 5000;

    logic                       clk = 1'b0;
    logic                       rst;
    logic signed   [SIGFIG-1:0] tri_i    [VERTS][AXIS];
    logic unsigned [SIGFIG-1:0] color_i  [COLORS];
    logic signed   [SIGFIG-1:0] box_i    [2][2];
    logic                       valid_i;
    logic          [3:0]        sub_i;
    logic                       halt_o;
    logic signed   [SIGFIG-1:0] tri_o    [VERTS][AXIS];
    logic unsigned [SIGFIG-1:0] color_o  [COLORS];
    logic signed   [SIGFIG-1:0] sample_o [2];
    logic                       vsamp_o;
`ifdef SAMPLE_ITER_PERF_EN
    logic          [31:0]       count_o;
`endif

    int checks = 0;
    int errors = 0;

    sample_iterator #(.SIGFIG(SIGFIG), .RADIX(10), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)) dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_i),
        .color_R13U       (color_i),
        .box_R13S         (box_i),
        .validTri_R13H    (valid_i),
        .subSample_RnnnnU (sub_i),
        .halt_RnnnnL      (halt_o),
        .tri_R14S         (tri_o),
        .color_R14U       (color_o),
        .sample_R14S      (sample_o),
        .validSamp_R14H   (vsamp_o)
`ifdef SAMPLE_ITER_PERF_EN
        ,
        .sampleCount_U    (count_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_step(input logic [3:0] s);
        case (s)
            4'b1000: return 1024;
            4'b0100: return 512;
            4'b0010: return 256;
            4'b0001: return 128;
            default: return 1024;
        endcase
    endfunction

    // Presents one triangle (caller is 1 time unit after a rising edge), then follows
    // the sample stream against the raster model until validSamp drops.
    task automatic run_tri(input int llx, input int lly, input int urx, input int ury,
                           input logic [3:0] sub, input bit toggle,
                           output int n, output int fx, output int fy, output int lx, output int ly);
        int qx[$];
        int qy[$];
        int step;
        logic signed   [SIGFIG-1:0] exp_tri [VERTS][AXIS];
        logic unsigned [SIGFIG-1:0] exp_col [COLORS];
        step = model_step(sub);
        for (int y = lly; y <= ury; y += step)
            for (int x = llx; x <= urx; x += step) begin
                qx.push_back(x);
                qy.push_back(y);
            end
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                tri_i[v][a] = SIGFIG'($urandom);
        for (int c = 0; c < COLORS; c++) color_i[c] = SIGFIG'($urandom);
        exp_tri     = tri_i;
        exp_col     = color_i;
        box_i[0][0] = SIGFIG'(llx);
        box_i[0][1] = SIGFIG'(lly);
        box_i[1][0] = SIGFIG'(urx);
        box_i[1][1] = SIGFIG'(ury);
        sub_i       = sub;
        valid_i     = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        n = 0; fx = 0; fy = 0; lx = 0; ly = 0;
        while (vsamp_o && n < BOUND) begin
            if (toggle) begin
                valid_i     = ~valid_i;
                box_i[0][0] = SIGFIG'(llx - 4096);
                box_i[1][1] = SIGFIG'(ury + 8192);
                sub_i       = 4'b0001;
                tri_i[0][0] = ~tri_i[0][0];
            end
            if (n < qx.size()) begin
                chk("sample_x", int'(sample_o[0]), qx[n]);
                chk("sample_y", int'(sample_o[1]), qy[n]);
            end else begin
                chk("extra_sample", n, qx.size() - 1);
            end
            chk("halt_busy", halt_o, 0);
            chk("tri_hold", tri_o[0][0], exp_tri[0][0]);
            chk("tri_hold_last", tri_o[VERTS-1][AXIS-1], exp_tri[VERTS-1][AXIS-1]);
            chk("color_hold", color_o[COLORS-1], exp_col[COLORS-1]);
            if (n == 0) begin
                fx = int'(sample_o[0]);
                fy = int'(sample_o[1]);
            end
            lx = int'(sample_o[0]);
            ly = int'(sample_o[1]);
            n++;
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        if (n >= BOUND) chk("cycle_bound", n, qx.size());
        chk("sample_count", n, qx.size());
        chk("halt_idle", halt_o, 1);
    endtask

    typedef struct {
        int         llx, lly, urx, ury;
        logic [3:0] sub;
        bit         toggle;
        int         n_exp, fx, fy, lx, ly;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int n, fx, fy, lx, ly;
        vecs[0] = '{0, 0, 2048, 1024, 4'b1000, 1'b1, 6, 0, 0, 2048, 1024};
        vecs[1] = '{0, 0, 2048, 1024, 4'b0100, 1'b0, 15, 0, 0, 2048, 1024};
        vecs[2] = '{1024, 1024, 1024, 1024, 4'b1000, 1'b0, 1, 1024, 1024, 1024, 1024};
        vecs[3] = '{2048, 0, 1024, 0, 4'b1000, 1'b0, 0, 0, 0, 0, 0};
        vecs[4] = '{0, 0, 1024, 1024, 4'b0110, 1'b0, 4, 0, 0, 1024, 1024};
        vecs[5] = '{-256, -128, 0, 0, 4'b0001, 1'b0, 6, -256, -128, 0, 0};
        vecs[6] = '{0, 0, 1500, 0, 4'b1000, 1'b0, 2, 0, 0, 1024, 0};
        vecs[7] = '{8387583, 0, 8388607, 0, 4'b1000, 1'b0, 2, 8387583, 0, 8388607, 0};

        rst     = 1'b1;
        valid_i = 1'b0;
        sub_i   = 4'b1000;
        tri_i   = '{default: '0};
        color_i = '{default: '0};
        box_i   = '{default: '0};
        @(posedge clk); #1;
        tri_i[0][0] = 24'h123456;
        valid_i     = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        chk("reset_valid", vsamp_o, 0);
        chk("reset_halt", halt_o, 1);
        chk("reset_sample_x", int'(sample_o[0]), 0);
        chk("reset_tri", tri_o[0][0], 0);
        chk("reset_color", color_o[0], 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_tri(vecs[i].llx, vecs[i].lly, vecs[i].urx, vecs[i].ury, vecs[i].sub,
                    vecs[i].toggle, n, fx, fy, lx, ly);
            chk($sformatf("vec%0d_count", i), n, vecs[i].n_exp);
            if (vecs[i].n_exp > 0) begin
                chk($sformatf("vec%0d_first_x", i), fx, vecs[i].fx);
                chk($sformatf("vec%0d_first_y", i), fy, vecs[i].fy);
                chk($sformatf("vec%0d_last_x", i), lx, vecs[i].lx);
                chk($sformatf("vec%0d_last_y", i), ly, vecs[i].ly);
            end
`ifdef SAMPLE_ITER_PERF_EN
            if (i == 0) chk("perf_count", count_o, 6);
`endif
        end

        // Reset lands while the third sample is on the outputs.
        tri_i[0][0] = 24'h0000aa;
        color_i[0]  = 24'h0000bb;
        box_i[0][0] = 24'd0;
        box_i[0][1] = 24'd0;
        box_i[1][0] = 24'd2048;
        box_i[1][1] = 24'd1024;
        sub_i       = 4'b1000;
        valid_i     = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        chk("abort_s1_x", int'(sample_o[0]), 0);
        @(posedge clk); #1;
        chk("abort_s2_x", int'(sample_o[0]), 1024);
        @(posedge clk); #1;
        chk("abort_s3_x", int'(sample_o[0]), 2048);
        chk("abort_s3_valid", vsamp_o, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_valid", vsamp_o, 0);
        chk("abort_halt", halt_o, 1);
        chk("abort_sample", int'(sample_o[0]), 0);
        chk("abort_tri", tri_o[0][0], 0);
        run_tri(512, 256, 1536, 1280, 4'b1000, 1'b0, n, fx, fy, lx, ly);
        chk("after_abort_count", n, 4);
        chk("after_abort_first_x", fx, 512);
        chk("after_abort_first_y", fy, 256);
`ifdef SAMPLE_ITER_PERF_EN
        chk("perf_after_reset", count_o, 4);
`endif

        for (int k = 0; k < 20; k++) begin
            int llx, lly, w, h;
            llx = int'($urandom_range(0, 4000)) - 2000;
            lly = int'($urandom_range(0, 4000)) - 2000;
            w   = int'($urandom_range(0, 2500)) - 100;
            h   = int'($urandom_range(0, 2500)) - 100;
            run_tri(llx, lly, llx + w, lly + h, 4'($urandom), 1'($urandom), n, fx, fy, lx, ly);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
